// File: rtl/axis_video_sink_checker_if.sv
// rtl/axis_video_sink_checker_if.sv - 4-pixel-per-clock video stream bundle
interface axis_video_sink_checker_if;
  logic [95:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;

  modport master (output tdata, tvalid, tuser, tlast, input tready);
  modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/axis_video_sink_checker.sv
// rtl/axis_video_sink_checker.sv - video sink with backpressure, geometry checks and frame checksum
module axis_video_sink_checker #(
  parameter int H_BEATS   = 16,
  parameter int V_LINES   = 64,
  parameter int READY_ON  = 10,
  parameter int READY_OFF = 1
) (
  input  logic                            s_axis_video_aclk,
  input  logic                            s_axis_video_areset,
  axis_video_sink_checker_if.slave        VIDEO_IN,
  input  logic                            err_clear,
  output logic                            frame_done,
  output logic                            frame_ok,
  output logic [15:0]                     frame_count,
  output logic [31:0]                     frame_checksum,
  output logic                            err_missing_sof,
  output logic                            err_sof_early,
  output logic                            err_eol_early,
  output logic                            err_eol_late
);
  localparam int BW = $clog2(H_BEATS + 3);
  localparam int LW = $clog2(V_LINES + 1);
  localparam int PW = $clog2(READY_ON + READY_OFF + 1);
  localparam logic [BW-1:0] H_L     = BW'(H_BEATS);
  localparam logic [BW-1:0] H_SAT   = BW'(H_BEATS + 1);
  localparam logic [LW-1:0] V_LAST  = LW'(V_LINES - 1);
  localparam logic [PW-1:0] ON_L    = PW'(READY_ON);
  localparam logic [PW-1:0] P_LAST  = PW'(READY_ON + READY_OFF - 1);

  typedef enum logic {ST_WAIT_SOF, ST_IN_FRAME} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [LW-1:0] line_cnt_q, line_cnt_d;
  logic [PW-1:0] bp_cnt_q, bp_cnt_d;
  logic [31:0]   csum_q, csum_d;
  logic          frame_err_q, frame_err_d;
  logic          tready_q, tready_d;
  logic          frame_done_q, frame_done_d;
  logic          frame_ok_q, frame_ok_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic [31:0]   frame_checksum_q, frame_checksum_d;
  logic          missing_sof_q, missing_sof_d;
  logic          sof_early_q, sof_early_d;
  logic          eol_early_q, eol_early_d;
  logic          eol_late_q, eol_late_d;

  logic          accept;
  logic [31:0]   beat_sum;
  logic [BW-1:0] bc;
  logic [LW-1:0] line;
  logic [31:0]   csum;
  logic          fe;

  always_comb begin
    state_d          = state_q;
    beat_cnt_d       = beat_cnt_q;
    line_cnt_d       = line_cnt_q;
    bp_cnt_d         = bp_cnt_q;
    csum_d           = csum_q;
    frame_err_d      = frame_err_q;
    tready_d         = tready_q;
    frame_done_d     = 1'b0;
    frame_ok_d       = frame_ok_q;
    frame_count_d    = frame_count_q;
    frame_checksum_d = frame_checksum_q;
    missing_sof_d    = missing_sof_q & ~err_clear;
    sof_early_d      = sof_early_q & ~err_clear;
    eol_early_d      = eol_early_q & ~err_clear;
    eol_late_d       = eol_late_q & ~err_clear;
    bc               = '0;
    line             = '0;
    csum             = '0;
    fe               = 1'b0;
    accept           = VIDEO_IN.tvalid & tready_q;

    beat_sum = '0;
    for (int k = 0; k < 12; k++) begin
      beat_sum = beat_sum + {24'd0, VIDEO_IN.tdata[8*k +: 8]};
    end

    if (READY_OFF == 0) begin
      tready_d = 1'b1;
    end else begin
      tready_d = (bp_cnt_q < ON_L);
      bp_cnt_d = (bp_cnt_q == P_LAST) ? '0 : bp_cnt_q + PW'(1);
    end

    if (accept) begin
      if (state_q == ST_WAIT_SOF && !VIDEO_IN.tuser) begin
        missing_sof_d = 1'b1;
      end else begin
        // A tuser beat always opens a fresh frame, abandoning any partial one.
        if (state_q == ST_IN_FRAME && VIDEO_IN.tuser) sof_early_d = 1'b1;
        bc   = VIDEO_IN.tuser ? '0   : beat_cnt_q;
        line = VIDEO_IN.tuser ? '0   : line_cnt_q;
        fe   = VIDEO_IN.tuser ? 1'b0 : frame_err_q;
        csum = (VIDEO_IN.tuser ? 32'd0 : csum_q) + beat_sum;
        if (VIDEO_IN.tlast && ((bc + BW'(1)) < H_L)) begin
          eol_early_d = 1'b1;
          fe          = 1'b1;
        end
        if (bc == H_L) begin
          eol_late_d = 1'b1;
          fe         = 1'b1;
        end
        csum_d      = csum;
        frame_err_d = fe;
        state_d     = ST_IN_FRAME;
        if (VIDEO_IN.tlast) begin
          beat_cnt_d = '0;
          if (line == V_LAST) begin
            frame_done_d     = 1'b1;
            frame_ok_d       = ~fe;
            frame_checksum_d = csum;
            frame_count_d    = frame_count_q + 16'd1;
            line_cnt_d       = '0;
            state_d          = ST_WAIT_SOF;
          end else begin
            line_cnt_d = line + LW'(1);
          end
        end else begin
          beat_cnt_d = (bc == H_SAT) ? bc : bc + BW'(1);
          line_cnt_d = line;
        end
      end
    end
  end

  always_ff @(posedge s_axis_video_aclk or posedge s_axis_video_areset) begin
    if (s_axis_video_areset) begin
      state_q          <= ST_WAIT_SOF;
      beat_cnt_q       <= '0;
      line_cnt_q       <= '0;
      bp_cnt_q         <= '0;
      csum_q           <= '0;
      frame_err_q      <= 1'b0;
      tready_q         <= 1'b0;
      frame_done_q     <= 1'b0;
      frame_ok_q       <= 1'b0;
      frame_count_q    <= '0;
      frame_checksum_q <= '0;
      missing_sof_q    <= 1'b0;
      sof_early_q      <= 1'b0;
      eol_early_q      <= 1'b0;
      eol_late_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      beat_cnt_q       <= beat_cnt_d;
      line_cnt_q       <= line_cnt_d;
      bp_cnt_q         <= bp_cnt_d;
      csum_q           <= csum_d;
      frame_err_q      <= frame_err_d;
      tready_q         <= tready_d;
      frame_done_q     <= frame_done_d;
      frame_ok_q       <= frame_ok_d;
      frame_count_q    <= frame_count_d;
      frame_checksum_q <= frame_checksum_d;
      missing_sof_q    <= missing_sof_d;
      sof_early_q      <= sof_early_d;
      eol_early_q      <= eol_early_d;
      eol_late_q       <= eol_late_d;
    end
  end

  assign VIDEO_IN.tready = tready_q;
  assign frame_done      = frame_done_q;
  assign frame_ok        = frame_ok_q;
  assign frame_count     = frame_count_q;
  assign frame_checksum  = frame_checksum_q;
  assign err_missing_sof = missing_sof_q;
  assign err_sof_early   = sof_early_q;
  assign err_eol_early   = eol_early_q;
  assign err_eol_late    = eol_late_q;
endmodule

// File: tb/tb_axis_video_sink_checker.sv
// tb/tb_axis_video_sink_checker.sv - directed/random bench for axis_video_sink_checker
module tb_axis_video_sink_checker;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [95:0] tdata = '0;
  logic        tvalid = 1'b0, tuser = 1'b0, tlast = 1'b0;
  logic        sel = 1'b0, err_clear = 1'b0;

  always #5 clk = ~clk;

  axis_video_sink_checker_if vin0 ();
  axis_video_sink_checker_if vin1 ();
  assign vin0.tdata  = tdata;
  assign vin0.tuser  = tuser;
  assign vin0.tlast  = tlast;
  assign vin0.tvalid = tvalid & ~sel;
  assign vin1.tdata  = tdata;
  assign vin1.tuser  = tuser;
  assign vin1.tlast  = tlast;
  assign vin1.tvalid = tvalid & sel;

  logic        fd0, fo0, ms0, se0, ee0, el0;
  logic [15:0] fc0;
  logic [31:0] cs0;
  logic        fd1, fo1, ms1, se1, ee1, el1;
  logic [15:0] fc1;
  logic [31:0] cs1;

  axis_video_sink_checker dut0 (
    .s_axis_video_aclk(clk), .s_axis_video_areset(rst), .VIDEO_IN(vin0.slave),
    .err_clear(err_clear), .frame_done(fd0), .frame_ok(fo0), .frame_count(fc0),
    .frame_checksum(cs0), .err_missing_sof(ms0), .err_sof_early(se0),
    .err_eol_early(ee0), .err_eol_late(el0));

  axis_video_sink_checker #(.READY_OFF(0)) dut1 (
    .s_axis_video_aclk(clk), .s_axis_video_areset(rst), .VIDEO_IN(vin1.slave),
    .err_clear(err_clear), .frame_done(fd1), .frame_ok(fo1), .frame_count(fc1),
    .frame_checksum(cs1), .err_missing_sof(ms1), .err_sof_early(se1),
    .err_eol_early(ee1), .err_eol_late(el1));

  int          checks = 0, errors = 0;
  int          done0 = 0;
  int          exp_count = 0;
  int          d_before;
  bit          toggle_mode = 1'b0, ones_mode = 1'b0;
  logic [31:0] exp_sum = '0;

  always @(negedge clk) if (fd0) done0++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] byte_sum(input logic [95:0] d);
    logic [31:0] s = 0;
    for (int k = 0; k < 12; k++) s += 32'(d[8*k +: 8]);
    return s;
  endfunction

  task automatic beat(input logic [95:0] d, input logic u, input logic l);
    int guard = 0;
    if (toggle_mode || $urandom_range(0, 3) == 0) begin
      tvalid = 1'b0;
      @(negedge clk);
    end
    tdata = d; tuser = u; tlast = l; tvalid = 1'b1;
    while (!(sel ? vin1.tready : vin0.tready) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      checks++; errors++;
      $error("FAIL ready_timeout observed=%0d expected=<20", guard);
    end
    if (sel) chk("ready_off0_high", 32'(vin1.tready), 32'd1);
    @(negedge clk);
    tvalid = 1'b0;
  endtask

  task automatic send_line(input int nbeats, input bit sof, input bit tl_end);
    logic [95:0] d;
    for (int b = 0; b < nbeats; b++) begin
      d = ones_mode ? {12{8'h01}} : {$urandom, $urandom, $urandom};
      if (sof && b == 0) exp_sum = 0;
      exp_sum += byte_sum(d);
      beat(d, sof && b == 0, (b == nbeats - 1) && tl_end);
    end
  endtask

  task automatic clean_frame();
    for (int l = 0; l < 64; l++) send_line(16, l == 0, 1'b1);
  endtask

  task automatic check_frame(input string tag, input logic ok);
    exp_count++;
    chk({tag, "_done"}, 32'(fd0), 32'd1);
    chk({tag, "_ok"}, 32'(fo0), 32'(ok));
    chk({tag, "_checksum"}, cs0, exp_sum);
    chk({tag, "_count"}, 32'(fc0), 32'(exp_count));
  endtask

  task automatic check_flags(input string tag, input logic [3:0] expf);
    chk({tag, "_flags"}, {28'd0, ms0, se0, ee0, el0}, {28'd0, expf});
  endtask

  task automatic clear_flags();
    @(negedge clk) err_clear = 1'b1;
    @(negedge clk) err_clear = 1'b0;
    check_flags("after_clear", 4'b0000);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {fd0, fo0, fc0, ms0, se0, ee0, el0}, 32'd0);
    chk("reset_checksum", cs0, 32'd0);
    chk("reset_tready", 32'(vin0.tready), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      chk("bp_pattern", 32'(vin0.tready), 32'((i % 11) < 10));
    end

    ones_mode = 1'b1;
    clean_frame();
    check_frame("ones1", 1'b1);
    chk("ones1_value", cs0, 32'h0000_3000);
    @(negedge clk);
    chk("done_one_cycle", 32'(fd0), 32'd0);
    clean_frame();
    check_frame("ones2", 1'b1);
    chk("ones2_value", cs0, 32'h0000_3000);
    check_flags("ones", 4'b0000);

    sel = 1'b1; toggle_mode = 1'b1;
    clean_frame();
    chk("off0_done", 32'(fd1), 32'd1);
    chk("off0_checksum", cs1, 32'h0000_3000);
    chk("off0_count", 32'(fc1), 32'd1);
    sel = 1'b0; toggle_mode = 1'b0; ones_mode = 1'b0;

    for (int i = 0; i < 5; i++) beat({$urandom, $urandom, $urandom}, 1'b0, 1'($urandom));
    clean_frame();
    check_frame("missing_sof", 1'b1);
    check_flags("missing_sof", 4'b1000);
    clear_flags();

    for (int l = 0; l < 64; l++) send_line(l == 3 ? 10 : 16, l == 0, 1'b1);
    check_frame("eol_early", 1'b0);
    check_flags("eol_early", 4'b0010);
    clear_flags();

    for (int l = 0; l < 64; l++) send_line(l == 0 ? 17 : 16, l == 0, 1'b1);
    check_frame("eol_late", 1'b0);
    check_flags("eol_late", 4'b0001);
    clear_flags();

    d_before = done0;
    for (int l = 0; l < 20; l++) send_line(16, l == 0, 1'b1);
    send_line(5, 1'b0, 1'b0);
    clean_frame();
    check_frame("sof_early", 1'b1);
    check_flags("sof_early", 4'b0100);
    @(negedge clk);
    chk("sof_early_pulses", 32'(done0 - d_before), 32'd1);
    clear_flags();

    for (int l = 0; l < 30; l++) send_line(16, l == 0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_count", 32'(fc0), 32'd0);
    chk("async_reset_checksum", cs0, 32'd0);
    chk("async_reset_tready", 32'(vin0.tready), 32'd0);
    @(negedge clk) rst = 1'b0;
    exp_count = 0;
    clean_frame();
    check_frame("after_reset", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
